// File: rtl/fnd_controller_if.sv
// rtl/fnd_controller_if.sv - value/update request and display outputs of the FND controller
interface fnd_controller_if;
    logic [7:0] value;
    logic       update;
    logic       busy;
    logic       done;
    logic [3:0] fndCom;
    logic [7:0] fndFont;

    modport master (
        output value,
        output update,
        input  busy,
        input  done,
        input  fndCom,
        input  fndFont
    );

    modport slave (
        input  value,
        input  update,
        output busy,
        output done,
        output fndCom,
        output fndFont
    );
endinterface

// File: rtl/fnd_controller.sv
// rtl/fnd_controller.sv - 8-bit binary to BCD (double-dabble) with multiplexed 4-digit FND drive
module fnd_controller #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic             clk,
    input  logic             reset,
    fnd_controller_if.slave  bus
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  bin;
    logic [11:0] bcd;
    logic [2:0]  iter;
    logic        done_r;

    logic [3:0]  disp_hund;
    logic [3:0]  disp_tens;
    logic [3:0]  disp_ones;

    logic [PW-1:0] presc;
    logic [1:0]    index;

    logic        load;
    logic        shift_en;
    logic        finish;
    logic [11:0] bcd_adj;
    logic [11:0] bcd_nxt;
    logic [7:0]  bin_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: update restarts from either state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.update) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (bus.update)        state_nxt = SHIFT;
                else if (iter == 3'd7) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        load     = bus.update;
        shift_en = (state == SHIFT) && !bus.update;
        finish   = shift_en && (iter == 3'd7);
        bus.busy = (state == SHIFT);
    end

    // One double-dabble step: add 3 to any nibble >= 5, then shift {bcd, bin} left
    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < 3; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) begin
                bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
            end
        end
        bcd_nxt = {bcd_adj[10:0], bin[7]};
        bin_nxt = {bin[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bin       <= '0;
            bcd       <= '0;
            iter      <= '0;
            done_r    <= 1'b0;
            disp_hund <= '0;
            disp_tens <= '0;
            disp_ones <= '0;
        end else begin
            done_r <= finish;
            if (load) begin
                bin  <= bus.value;
                bcd  <= '0;
                iter <= '0;
            end else if (shift_en) begin
                bin  <= bin_nxt;
                bcd  <= bcd_nxt;
                iter <= iter + 3'd1;
            end
            // Latch the post-shift result so no partial digits ever reach the display
            if (finish) begin
                disp_hund <= bcd_nxt[11:8];
                disp_tens <= bcd_nxt[7:4];
                disp_ones <= bcd_nxt[3:0];
            end
        end
    end

    assign bus.done = done_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc <= '0;
            index <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            index <= index + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    function automatic logic [7:0] font(input logic [3:0] d);
        case (d)
            4'd0:    font = 8'hC0;
            4'd1:    font = 8'hF9;
            4'd2:    font = 8'hA4;
            4'd3:    font = 8'hB0;
            4'd4:    font = 8'h99;
            4'd5:    font = 8'h92;
            4'd6:    font = 8'h82;
            4'd7:    font = 8'hF8;
            4'd8:    font = 8'h80;
            4'd9:    font = 8'h90;
            default: font = 8'hFF;
        endcase
    endfunction

    logic blank_hund;
    logic blank_tens;

    always_comb begin
        blank_hund = (BLANK_LZ != 0) && (disp_hund == 4'd0);
        blank_tens = blank_hund && (disp_tens == 4'd0);
        bus.fndCom = ~(4'b0001 << index);
        case (index)
            2'd0:    bus.fndFont = font(disp_ones);
            2'd1:    bus.fndFont = blank_tens ? 8'hFF : font(disp_tens);
            2'd2:    bus.fndFont = blank_hund ? 8'hFF : font(disp_hund);
            default: bus.fndFont = 8'hFF;
        endcase
    end

endmodule

// File: doc/fnd_controller.md
# fnd_controller

Downstream display stage for the summing datapath. Takes the datapath's 8-bit result, converts it to three BCD digits with a sequential double-dabble unit, and drives a 4-digit common-anode 7-segment (FND) display by time-multiplexing the digits. It holds the last converted value until a new `update` pulse arrives.

## Interface
- `CLK_HZ`, 100_000_000: input clock frequency.
- `SCAN_HZ`, 1000: digit-advance rate. `DIV = CLK_HZ/SCAN_HZ` must be ≥ 2.
- `BLANK_LZ`, 1: when 1, leading zeros are blanked. When 0, hundreds and tens always show.

- `clk`, in, 1: system clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- `value`, in, 8: unsigned binary to display. Connects to the datapath `out`.
- `update`, in, 1: sample `value` and start conversion.
- `busy`, out, 1: conversion in progress.
- `done`, out, 1: one-cycle pulse when the new digits are latched into the display.
- `fndCom`, out, 4: active-low digit enables. Bit 0 = ones (rightmost), bit 3 = thousands.
- `fndFont`, out, 8: active-low segments `{dp,g,f,e,d,c,b,a}`. `dp` is always 1.

## Operation
- **Converter FSM**, states IDLE and SHIFT.
  - In IDLE, `update`=1 loads `value` into the shift register, clears the BCD nibbles and the iteration counter, and moves to SHIFT.
  - Each SHIFT cycle: any BCD nibble ≥ 5 has 3 added, then `{bcd, bin}` shifts left by 1.
  - After the 8th shift, the FSM latches the hundreds, tens and ones nibbles into the display registers, pulses `done`, and returns to IDLE.
- `update` during SHIFT restarts the conversion with the new `value`. The iteration counter clears to 0 and the display registers are untouched.
- Digits range 0–2 / 0–9 / 0–9 (max 255). The thousands digit is always blank (`8'hFF`).
- **Font map**, active-low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
- **Blanking** (BLANK_LZ=1):
  - hundreds is blank if it is 0;
  - tens is blank if hundreds=0 and tens=0;
  - ones is never blank.
- **Scan**:
  - The prescaler counts 0..DIV-1 and wraps.
  - A 2-bit digit index advances 0→1→2→3→0 on the edge where the prescaler equals DIV-1.
  - `fndCom` is `~(4'b0001 << index)`. `fndFont` is the font of the displayed digit at that index.
  - Both are combinational from registered state. Exactly one `fndCom` bit is low at all times.

## Timing
- **Reset** (`reset`=0 at an edge) sets:
  - FSM = IDLE, `busy`=0, `done`=0;
  - prescaler = 0, digit index = 0;
  - all display digits = 0.
  - Resulting outputs: `fndCom`=4'b1110, `fndFont`=8'hC0.
- Reset overrides `update` and aborts a conversion in progress, with no `done` pulse.
- **Conversion latency**:
  - `update` is sampled at edge E.
  - `busy`=1 after edge E through edge E+8.
  - The display registers and `done`=1 update at edge E+8.
  - `busy`=0 and `done`=0 after edge E+9.
- Back-to-back: `update` held high in IDLE and SHIFT keeps restarting, so no `done` pulse occurs until `update` is low.
- The digit index changes once every DIV cycles; the first advance is at edge DIV after reset release. The scan runs independently of conversion.
- New digits appear on the currently selected position in the same cycle the display registers change. No intermediate (partially converted) digits are ever visible.

## Test plan
- **Reset**: hold `reset`=0 for 3 cycles, then release → `fndCom`=1110, `fndFont`=C0, `busy`=0; with DIV=4, index 1 is selected after 4 cycles.
- **Value 55**: `update` pulse with `value`=55 (CLK_HZ=8, SCAN_HZ=2) → `busy` high for 8 cycles; `done` at E+8; scan shows ones=92, tens=92, hundreds=FF, thousands=FF.
- **Value 255**: `value`=255, BLANK_LZ=0 → fonts ones=92, tens=92, hundreds=A4, thousands=FF.
- **Blanking, value 7**: `value`=7, BLANK_LZ=1 → ones=F8, tens=FF, hundreds=FF. Repeat with `value`=0 → ones=C0, others FF.
- **Restart**: `update` with 100, then `update` with 9 at E+4 → display stays at its previous value until E+12; then ones=90, others blank; exactly one `done` pulse.
- **Reset mid-conversion**: `reset`=0 at E+3 → `busy`=0, digits 0, no `done`; a subsequent `update` of 42 converts normally.
